imm_pack: RTL and testbench

Immediate packer: the inverse of the decode-side sign-extension unit. It takes a 32-bit immediate value, an extension-format code and a 32-bit instruction template, and checks that the value is representable in that format. It then scatters the value's bits into the template's immediate fields and emits the finished instruction word through a 2-stage valid/ready pipeline. It sits between the debug/boot loader (or a test-program generator) and the instruction-memory write port, so patched branch offsets and constants round-trip exactly through the decode-side extender.

---
 rtl/imm_pack.sv | 151 +++++++++++++++
 tb/tb_imm_pack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_pack.sv
// imm_pack: packs a 32-bit immediate into an instruction template's immediate
// fields after checking it is representable in the requested format. Two
// register stages (S1 operands, S2 result) with valid/ready flow control.
`timescale 1ns/1ps

`ifndef EXT_I5
`define EXT_I5   3'd0
`endif
`ifndef EXT_I12
`define EXT_I12  3'd1
`endif
`ifndef EXT_I12U
`define EXT_I12U 3'd2
`endif
`ifndef EXT_I20
`define EXT_I20  3'd3
`endif
`ifndef EXT_I16
`define EXT_I16  3'd4
`endif
`ifndef EXT_I26
`define EXT_I26  3'd5
`endif

module imm_pack (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [31:0] in_val,
  input  logic [31:0] in_tmpl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  logic        r_s1_valid;
  logic [2:0]  r_s1_fmt;
  logic [31:0] r_s1_val;
  logic [31:0] r_s1_tmpl;
  logic        r_s2_valid;
  logic [31:0] r_s2_inst;
  logic        r_s2_err;
  logic [15:0] r_err_cnt;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_legal;
  logic [31:0] w_mask;
  logic [31:0] w_field;
  logic [31:0] w_inst;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  // Held low while reset is asserted so nothing is accepted into a clearing pipe.
  assign in_ready  = cpu_rst_n && w_s1_adv;

  assign out_valid = r_s2_valid;
  assign out_inst  = r_s2_inst;
  assign out_err   = r_s2_err;
  assign err_cnt   = r_err_cnt;

  // Legality check and field scatter for the operands held in S1.
  always_comb begin
    w_legal = 1'b0;
    w_mask  = 32'h0;
    w_field = 32'h0;
    case (r_s1_fmt)
      `EXT_I5: begin
        w_legal = ~|r_s1_val[31:5];
        w_mask  = 32'h0000_7C00;
        w_field = {17'b0, r_s1_val[4:0], 10'b0};
      end
      `EXT_I12: begin
        w_legal = (&r_s1_val[31:11]) || (~|r_s1_val[31:11]);
        w_mask  = 32'h003F_FC00;
        w_field = {10'b0, r_s1_val[11:0], 10'b0};
      end
      `EXT_I12U: begin
        w_legal = ~|r_s1_val[31:12];
        w_mask  = 32'h003F_FC00;
        w_field = {10'b0, r_s1_val[11:0], 10'b0};
      end
      `EXT_I20: begin
        w_legal = ~|r_s1_val[11:0];
        w_mask  = 32'h01FF_FFE0;
        w_field = {7'b0, r_s1_val[31:12], 5'b0};
      end
      `EXT_I16: begin
        w_legal = (~|r_s1_val[1:0]) &&
                  ((&r_s1_val[31:17]) || (~|r_s1_val[31:17]));
        w_mask  = 32'h03FF_FC00;
        w_field = {6'b0, r_s1_val[17:2], 10'b0};
      end
      `EXT_I26: begin
        // Sign reference is bit 27, so bits 31:27 must all agree.
        w_legal = (~|r_s1_val[1:0]) &&
                  ((&r_s1_val[31:27]) || (~|r_s1_val[31:27]));
        w_mask  = 32'h03FF_FFFF;
        w_field = {6'b0, r_s1_val[17:2], r_s1_val[27:18]};
      end
      default: w_legal = 1'b0;
    endcase
    // Illegal requests pass the template through untouched.
    w_inst = w_legal ? ((r_s1_tmpl & ~w_mask) | w_field) : r_s1_tmpl;
  end

  // S1: capture request operands when the stage can advance.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_fmt   <= 3'b0;
      r_s1_val   <= 32'h0;
      r_s1_tmpl  <= 32'h0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_fmt  <= in_fmt;
        r_s1_val  <= in_val;
        r_s1_tmpl <= in_tmpl;
      end
    end
  end

  // S2: register merged instruction and error flag; held while stalled.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= 32'h0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_inst <= w_inst;
        r_s2_err  <= !w_legal;
      end
    end
  end

  // Saturating count of erroring results that leave through the output handshake.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n)
      r_err_cnt <= 16'h0;
    else if (r_s2_valid && out_ready && r_s2_err && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: directed vectors with hand-computed packed words; an in-order
// expected queue is compared against every presented result.
`timescale 1ns/1ps

`ifndef EXT_I5
`define EXT_I5   3'd0
`endif
`ifndef EXT_I12
`define EXT_I12  3'd1
`endif
`ifndef EXT_I12U
`define EXT_I12U 3'd2
`endif
`ifndef EXT_I20
`define EXT_I20  3'd3
`endif
`ifndef EXT_I16
`define EXT_I16  3'd4
`endif
`ifndef EXT_I26
`define EXT_I26  3'd5
`endif

module tb_imm_pack;
  logic        cpu_clk   = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt    = 3'b0;
  logic [31:0] in_val    = 32'h0;
  logic [31:0] in_tmpl   = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [32:0] expq[$];  // {err, inst}, oldest first

  imm_pack dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_val(in_val), .in_tmpl(in_tmpl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present one request, wait for acceptance, record its expected result.
  task automatic send(input logic [2:0] f, input logic [31:0] v, input logic [31:0] t,
                      input logic [31:0] ei, input logic ee);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_fmt   = f;
    in_val   = v;
    in_tmpl  = t;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge cpu_clk);
      acc = in_ready;
      @(posedge cpu_clk);
      #1;
    end
    if (acc) expq.push_back({ee, ei});
    else chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && expq.size() != 0; k++) begin
      @(posedge cpu_clk);
      #1;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 32'd0);
  endtask

  // Output monitor: every presented result must match the queue head, which
  // also proves stability while stalled; in_ready falls only with both stages
  // occupied and the consumer stalled.
  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      chk("in_ready", in_ready, !(expq.size() == 2 && !out_ready));
      if (out_valid) begin
        if (expq.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          chk("out_inst", out_inst, expq[0][31:0]);
          chk("out_err", out_err, expq[0][32]);
          if (out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset state
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge cpu_clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_inst", out_inst, 0);
      chk("rst_err", out_err, 0);
      chk("rst_cnt", err_cnt, 0);
      chk("rst_ready", in_ready, 0);
    end
    #2 cpu_rst_n = 1'b1;
    @(posedge cpu_clk); #1;

    // Latency: FFFF_F800 -> field 0x800 at [21:10] -> 0x0020_0000 | tmpl
    in_valid = 1'b1; in_fmt = `EXT_I12; in_val = 32'hFFFF_F800; in_tmpl = 32'h0280_0000;
    @(negedge cpu_clk);
    chk("lat_ready", in_ready, 1);
    chk("lat_v0", out_valid, 0);
    @(posedge cpu_clk); #1;
    expq.push_back({1'b0, 32'h02A0_0000});
    in_valid = 1'b0;
    @(negedge cpu_clk);
    chk("lat_v1", out_valid, 0);
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk);
    chk("lat_v2", out_valid, 1);
    drain();

    // Format sweep
    send(`EXT_I20, 32'h1234_5000, 32'h0, 32'h0024_68A0, 1'b0); // 0x12345 << 5
    send(`EXT_I16, 32'hFFFF_FFFC, 32'h0, 32'h03FF_FC00, 1'b0); // 0xFFFF << 10
    send(`EXT_I26, 32'h0000_0004, 32'h5000_0000, 32'h5000_0400, 1'b0);
    drain();

    // Illegal values
    chk("cnt_before_ill", err_cnt, 0);
    send(`EXT_I5,   32'd32,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    send(`EXT_I16,  32'd6,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    send(`EXT_I12U, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    send(3'b111,    32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    drain();
    chk("cnt_after_ill", err_cnt, 4);

    // Backpressure: out_ready pattern 1,0,0 repeating
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          out_ready = (i % 3 == 0);
          @(posedge cpu_clk); #1;
        end
      end
      begin
        send(`EXT_I5,   32'h0000_001F, 32'h0,          32'h0000_7C00, 1'b0);
        send(`EXT_I12,  32'h0000_07FF, 32'hFFFF_FFFF,  32'hFFDF_FFFF, 1'b0);
        send(`EXT_I12U, 32'h0000_0FFF, 32'h0,          32'h003F_FC00, 1'b0);
        send(`EXT_I20,  32'hFFFF_F000, 32'h0,          32'h01FF_FFE0, 1'b0);
        send(`EXT_I16,  32'h0001_FFFC, 32'h0,          32'h01FF_FC00, 1'b0);
        send(`EXT_I26,  32'hF800_0000, 32'h0,          32'h0000_0200, 1'b0);
        send(`EXT_I5,   32'h0000_0020, 32'h1234_5678,  32'h1234_5678, 1'b1);
        send(`EXT_I12,  32'hFFFF_F7FF, 32'hA5A5_A5A5,  32'hA5A5_A5A5, 1'b1);
      end
    join
    out_ready = 1'b1;
    drain();
    chk("cnt_after_bp", err_cnt, 6);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(`EXT_I5, 32'h1, 32'h0, 32'h0000_0400, 1'b0);
    send(`EXT_I5, 32'h2, 32'h0, 32'h0000_0800, 1'b0);
    @(negedge cpu_clk);
    chk("full_valid", out_valid, 1);
    #2 cpu_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    expq.delete();
    repeat (2) @(negedge cpu_clk);
    #2 cpu_rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge cpu_clk);
      chk("post_rst_valid", out_valid, 0);
    end
    @(posedge cpu_clk); #1;

    // Saturation
    for (int i = 0; i < 65534; i++) send(3'b111, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    drain();
    chk("cnt_fffe", err_cnt, 16'hFFFE);
    send(3'b110, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1);
    drain();
    chk("cnt_ffff", err_cnt, 16'hFFFF);
    send(3'b111, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    send(3'b111, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    drain();
    chk("cnt_hold", err_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
